// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use detection and a single-entry multi-cycle
// scoreboard for the EX/MEM/WB pipeline; all hazard outputs are combinational.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic [REG_AW-1:0] ID_rs3,
  input  logic [2:0]        ID_rs_use,
  input  logic [2:0]        ID_rs_fp,
  input  logic [REG_AW-1:0] ID_rd,
  input  logic              ID_rd_we,
  input  logic              ID_rd_fp,
  input  logic              ID_is_mc,
  input  logic [REG_AW-1:0] EX_rs1,
  input  logic [REG_AW-1:0] EX_rs2,
  input  logic [REG_AW-1:0] EX_rs3,
  input  logic [2:0]        EX_rs_fp,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic              EX_reg_wr_en,
  input  logic              EX_freg_wr_en,
  input  logic              EX_is_load,
  input  logic              EX_mc_start,
  input  logic [REG_AW-1:0] MEM_rd,
  input  logic              MEM_reg_wr_en,
  input  logic              MEM_freg_wr_en,
  input  logic [REG_AW-1:0] WB_rd,
  input  logic              WB_reg_wr_en,
  input  logic              WB_freg_wr_en,
  output logic [1:0]        EX_fwd_sel1,
  output logic [1:0]        EX_fwd_sel2,
  output logic [1:0]        EX_fwd_sel3,
  output logic              stall,
  output logic              flush_ex,
  output logic              mc_busy,
  output logic              mc_wb_valid,
  output logic [REG_AW-1:0] mc_wb_rd,
  output logic              mc_wb_fp,
  output logic              mc_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mc_state_t;

  localparam logic [7:0] CNT_INIT = 8'(MC_LAT - 1);

  mc_state_t         state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [REG_AW-1:0] pend_rd_reg, pend_rd_next;
  logic              pend_fp_reg, pend_fp_next;
  logic              mc_err_reg, mc_err_next;

  logic [REG_AW-1:0] ex_rs [3];
  logic [REG_AW-1:0] id_rs [3];
  logic [1:0]        fwd_sel [3];
  logic [2:0]        lu_hit;
  logic [2:0]        sb_src_hit;
  logic              sb_dst_hit;
  logic              ex_int_wr, ex_fp_wr;
  logic              pend_nz;
  logic              wb_free;
  logic              busy_int;
  logic              sb_hazard;

  assign ex_rs[0] = EX_rs1;
  assign ex_rs[1] = EX_rs2;
  assign ex_rs[2] = EX_rs3;
  assign id_rs[0] = ID_rs1;
  assign id_rs[1] = ID_rs2;
  assign id_rs[2] = ID_rs3;

  // A load in EX only blocks consumers of a register it will really write.
  assign ex_int_wr = EX_is_load && EX_reg_wr_en && (EX_rd != '0);
  assign ex_fp_wr  = EX_is_load && EX_freg_wr_en;

  // Integer x0 is hardwired, so a pending write to it never blocks anyone.
  assign pend_nz  = pend_fp_reg || (pend_rd_reg != '0);
  assign wb_free  = !WB_reg_wr_en && !WB_freg_wr_en;
  assign busy_int = (state_reg != ST_IDLE) && !rst;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
      logic mem_hit, wb_hit;

      assign mem_hit = (EX_rs_fp[gi] ? MEM_freg_wr_en
                                     : (MEM_reg_wr_en && (ex_rs[gi] != '0)))
                       && (MEM_rd == ex_rs[gi]);
      assign wb_hit  = (EX_rs_fp[gi] ? WB_freg_wr_en
                                     : (WB_reg_wr_en && (ex_rs[gi] != '0)))
                       && (WB_rd == ex_rs[gi]);
      assign fwd_sel[gi] = mem_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);

      assign lu_hit[gi] = ID_rs_use[gi]
                          && (ID_rs_fp[gi] ? ex_fp_wr : ex_int_wr)
                          && (id_rs[gi] == EX_rd);

      assign sb_src_hit[gi] = ID_rs_use[gi] && pend_nz
                              && (ID_rs_fp[gi] == pend_fp_reg)
                              && (id_rs[gi] == pend_rd_reg);
    end
  endgenerate

  assign sb_dst_hit = ID_rd_we && pend_nz && (ID_rd_fp == pend_fp_reg)
                      && (ID_rd == pend_rd_reg);

  // Only one multi-cycle op may be in flight, so a second one also waits.
  assign sb_hazard = busy_int && ((|sb_src_hit) || sb_dst_hit || ID_is_mc);

  assign EX_fwd_sel1 = fwd_sel[0];
  assign EX_fwd_sel2 = fwd_sel[1];
  assign EX_fwd_sel3 = fwd_sel[2];
  assign stall       = (|lu_hit) || sb_hazard;
  assign flush_ex    = stall;

  assign mc_busy  = busy_int;
  assign mc_wb_rd = busy_int ? pend_rd_reg : '0;
  assign mc_wb_fp = busy_int && pend_fp_reg;
  assign mc_err   = mc_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pend_rd_reg <= '0;
      pend_fp_reg <= 1'b0;
      mc_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pend_rd_reg <= pend_rd_next;
      pend_fp_reg <= pend_fp_next;
      mc_err_reg  <= mc_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pend_rd_next = pend_rd_reg;
    pend_fp_next = pend_fp_reg;
    mc_err_next  = mc_err_reg;
    mc_wb_valid  = 1'b0;

    if (EX_mc_start && (state_reg != ST_IDLE))
      mc_err_next = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (EX_mc_start) begin
          state_next   = ST_BUSY;
          cnt_next     = CNT_INIT;
          pend_rd_next = EX_rd;
          pend_fp_next = EX_freg_wr_en;
        end
      end
      ST_BUSY: begin
        if (cnt_reg == 8'd0)
          state_next = ST_DONE;
        else
          cnt_next = cnt_reg - 8'd1;
      end
      ST_DONE: begin
        // Result only retires when the regular WB port leaves the slot free.
        if (wb_free) begin
          mc_wb_valid = !rst;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized
// traffic checked against a cycle-count based reference model.
module tb_fwd_hazard_unit;

  localparam int AW  = 5;
  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ID_rs1, ID_rs2, ID_rs3, ID_rd;
  logic [2:0]    ID_rs_use, ID_rs_fp;
  logic          ID_rd_we, ID_rd_fp, ID_is_mc;
  logic [AW-1:0] EX_rs1, EX_rs2, EX_rs3, EX_rd;
  logic [2:0]    EX_rs_fp;
  logic          EX_reg_wr_en, EX_freg_wr_en, EX_is_load, EX_mc_start;
  logic [AW-1:0] MEM_rd, WB_rd;
  logic          MEM_reg_wr_en, MEM_freg_wr_en, WB_reg_wr_en, WB_freg_wr_en;
  logic [1:0]    EX_fwd_sel1, EX_fwd_sel2, EX_fwd_sel3;
  logic          stall, flush_ex, mc_busy, mc_wb_valid, mc_wb_fp, mc_err;
  logic [AW-1:0] mc_wb_rd;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: an op is in flight, and how many edges since it started
  bit            m_active;
  int            m_elapsed;
  logic [AW-1:0] m_rd;
  logic          m_fp;
  logic          m_err;

  logic [1:0]    e_sel [3];
  logic          e_stall, e_busy, e_valid, e_fp, e_err;
  logic [AW-1:0] e_rd;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(AW), .MC_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs3(ID_rs3),
    .ID_rs_use(ID_rs_use), .ID_rs_fp(ID_rs_fp),
    .ID_rd(ID_rd), .ID_rd_we(ID_rd_we), .ID_rd_fp(ID_rd_fp), .ID_is_mc(ID_is_mc),
    .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rs3(EX_rs3), .EX_rs_fp(EX_rs_fp),
    .EX_rd(EX_rd), .EX_reg_wr_en(EX_reg_wr_en), .EX_freg_wr_en(EX_freg_wr_en),
    .EX_is_load(EX_is_load), .EX_mc_start(EX_mc_start),
    .MEM_rd(MEM_rd), .MEM_reg_wr_en(MEM_reg_wr_en), .MEM_freg_wr_en(MEM_freg_wr_en),
    .WB_rd(WB_rd), .WB_reg_wr_en(WB_reg_wr_en), .WB_freg_wr_en(WB_freg_wr_en),
    .EX_fwd_sel1(EX_fwd_sel1), .EX_fwd_sel2(EX_fwd_sel2), .EX_fwd_sel3(EX_fwd_sel3),
    .stall(stall), .flush_ex(flush_ex),
    .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
    .mc_wb_fp(mc_wb_fp), .mc_err(mc_err)
  );

  function automatic logic [AW-1:0] id_src(int n);
    case (n)
      0:       return ID_rs1;
      1:       return ID_rs2;
      default: return ID_rs3;
    endcase
  endfunction

  function automatic logic [AW-1:0] ex_src(int n);
    case (n)
      0:       return EX_rs1;
      1:       return EX_rs2;
      default: return EX_rs3;
    endcase
  endfunction

  task automatic compute_expected();
    bit lu, sb;
    for (int n = 0; n < 3; n++) begin
      logic [AW-1:0] r;
      bit fp, in_mem, in_wb;
      r  = ex_src(n);
      fp = EX_rs_fp[n];
      in_mem = (fp ? MEM_freg_wr_en : MEM_reg_wr_en) && MEM_rd == r && (fp || r != 0);
      in_wb  = (fp ? WB_freg_wr_en  : WB_reg_wr_en)  && WB_rd  == r && (fp || r != 0);
      e_sel[n] = in_mem ? 2'd1 : (in_wb ? 2'd2 : 2'd0);
    end
    e_busy  = !rst && m_active;
    e_valid = e_busy && (m_elapsed >= LAT + 1) && !WB_reg_wr_en && !WB_freg_wr_en;
    e_rd    = e_busy ? m_rd : '0;
    e_fp    = e_busy && m_fp;
    e_err   = m_err;
    lu = 0;
    sb = 0;
    for (int n = 0; n < 3; n++) begin
      if (ID_rs_use[n]) begin
        if (EX_is_load && id_src(n) == EX_rd &&
            (ID_rs_fp[n] ? EX_freg_wr_en : (EX_reg_wr_en && EX_rd != 0)))
          lu = 1;
        if (e_busy && ID_rs_fp[n] == m_fp && id_src(n) == m_rd && (m_fp || m_rd != 0))
          sb = 1;
      end
    end
    if (e_busy && ID_is_mc) sb = 1;
    if (e_busy && ID_rd_we && ID_rd_fp == m_fp && ID_rd == m_rd && (m_fp || m_rd != 0))
      sb = 1;
    e_stall = lu || sb;
  endtask

  task automatic settle();
    #1;
    compute_expected();
  endtask

  // advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    compute_expected();
    if (rst) begin
      m_active = 0; m_elapsed = 0; m_rd = '0; m_fp = 0; m_err = 0;
    end else begin
      if (EX_mc_start && m_active) m_err = 1;
      if (m_active) begin
        if (e_valid) m_active = 0;
        else m_elapsed++;
      end else if (EX_mc_start) begin
        m_active = 1; m_elapsed = 1; m_rd = EX_rd; m_fp = EX_freg_wr_en;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs1 = '0; ID_rs2 = '0; ID_rs3 = '0; ID_rd = '0;
    ID_rs_use = '0; ID_rs_fp = '0; ID_rd_we = 0; ID_rd_fp = 0; ID_is_mc = 0;
    EX_rs1 = '0; EX_rs2 = '0; EX_rs3 = '0; EX_rs_fp = '0; EX_rd = '0;
    EX_reg_wr_en = 0; EX_freg_wr_en = 0; EX_is_load = 0; EX_mc_start = 0;
    MEM_rd = '0; MEM_reg_wr_en = 0; MEM_freg_wr_en = 0;
    WB_rd = '0; WB_reg_wr_en = 0; WB_freg_wr_en = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    settle();
    $display("reset: busy=%0b valid=%0b rd=%0d err=%0b", mc_busy, mc_wb_valid, mc_wb_rd, mc_err);
    n_cmp++; if (mc_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", mc_busy); end
    n_cmp++; if (mc_wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", mc_wb_valid); end
    n_cmp++; if (mc_wb_rd !== '0 || mc_wb_fp !== 1'b0) begin n_bad++; $display("FAIL reset_wb: got rd=%0d fp=%0b expected 0/0", mc_wb_rd, mc_wb_fp); end
    n_cmp++; if (mc_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b expected 0", mc_err); end
    rst = 0;
    settle();
    n_cmp++; if (stall !== 1'b0 || flush_ex !== 1'b0 || mc_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset: got stall=%0b flush=%0b busy=%0b expected 0/0/0", stall, flush_ex, mc_busy); end
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    EX_rs1 = 5; MEM_rd = 5; MEM_reg_wr_en = 1; WB_rd = 5; WB_reg_wr_en = 1;
    settle();
    $display("fwd mem>wb: sel1=%0d", EX_fwd_sel1);
    n_cmp++; if (EX_fwd_sel1 !== 2'b01) begin n_bad++; $display("FAIL fwd_mem_prio: got %0d expected 1", EX_fwd_sel1); end
    MEM_reg_wr_en = 0;
    settle();
    $display("fwd wb: sel1=%0d", EX_fwd_sel1);
    n_cmp++; if (EX_fwd_sel1 !== 2'b10) begin n_bad++; $display("FAIL fwd_wb: got %0d expected 2", EX_fwd_sel1); end
    EX_rs1 = 0; MEM_rd = 0; WB_rd = 0; MEM_reg_wr_en = 1;
    settle();
    $display("fwd int x0: sel1=%0d", EX_fwd_sel1);
    n_cmp++; if (EX_fwd_sel1 !== 2'b00) begin n_bad++; $display("FAIL fwd_x0: got %0d expected 0", EX_fwd_sel1); end
    MEM_reg_wr_en = 0; WB_reg_wr_en = 0; EX_rs_fp = 3'b001; MEM_freg_wr_en = 1;
    settle();
    $display("fwd fp f0: sel1=%0d", EX_fwd_sel1);
    n_cmp++; if (EX_fwd_sel1 !== 2'b01) begin n_bad++; $display("FAIL fwd_f0: got %0d expected 1", EX_fwd_sel1); end
    // integer write to r9 must not feed an FP read of f9
    clear_inputs();
    EX_rs3 = 9; EX_rs_fp = 3'b100; WB_rd = 9; WB_reg_wr_en = 1;
    settle();
    $display("fwd file mismatch: sel3=%0d", EX_fwd_sel3);
    n_cmp++; if (EX_fwd_sel3 !== 2'b00) begin n_bad++; $display("FAIL fwd_file: got %0d expected 0", EX_fwd_sel3); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    EX_is_load = 1; EX_rd = 7; EX_reg_wr_en = 1; ID_rs2 = 7; ID_rs_use = 3'b010;
    settle();
    $display("load-use int: stall=%0b flush=%0b", stall, flush_ex);
    n_cmp++; if (stall !== 1'b1 || flush_ex !== 1'b1) begin n_bad++; $display("FAIL lu_int: got %0b/%0b expected 1/1", stall, flush_ex); end
    ID_rs_fp = 3'b010;
    settle();
    $display("load-use other file: stall=%0b", stall);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_fp_mismatch: got %0b expected 0", stall); end
    ID_rs_fp = 3'b000; EX_rd = 0; ID_rs2 = 0;
    settle();
    $display("load-use x0: stall=%0b", stall);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_x0: got %0b expected 0", stall); end
    tick();
  endtask

  task automatic test_mc_timing();
    clear_inputs();
    EX_mc_start = 1; EX_rd = 3; EX_freg_wr_en = 1;
    settle();
    n_cmp++; if (mc_busy !== 1'b0) begin n_bad++; $display("FAIL mc_c0_busy: got %0b expected 0", mc_busy); end
    tick();
    clear_inputs();
    ID_rs1 = 3; ID_rs_use = 3'b001; ID_rs_fp = 3'b001;
    for (int c = 1; c <= 10; c++) begin
      settle();
      $display("mc cycle %0d: busy=%0b valid=%0b rd=%0d fp=%0b stall=%0b", c, mc_busy, mc_wb_valid, mc_wb_rd, mc_wb_fp, stall);
      n_cmp++; if (mc_busy !== (c <= 9)) begin n_bad++; $display("FAIL mc_busy c%0d: got %0b expected %0b", c, mc_busy, c <= 9); end
      n_cmp++; if (mc_wb_valid !== (c == 9)) begin n_bad++; $display("FAIL mc_valid c%0d: got %0b expected %0b", c, mc_wb_valid, c == 9); end
      n_cmp++; if (stall !== (c <= 9)) begin n_bad++; $display("FAIL mc_stall c%0d: got %0b expected %0b", c, stall, c <= 9); end
      if (c == 9) begin
        n_cmp++; if (mc_wb_rd !== 5'd3 || mc_wb_fp !== 1'b1) begin n_bad++; $display("FAIL mc_wb_tag: got rd=%0d fp=%0b expected 3/1", mc_wb_rd, mc_wb_fp); end
      end
      tick();
    end
  endtask

  task automatic test_done_blocked();
    clear_inputs();
    EX_mc_start = 1; EX_rd = 4; EX_reg_wr_en = 1;
    tick();
    clear_inputs();
    for (int c = 1; c <= 13; c++) begin
      ID_is_mc      = (c == 3);
      WB_freg_wr_en = (c >= 9 && c <= 11);
      settle();
      $display("done-block cycle %0d: busy=%0b valid=%0b stall=%0b", c, mc_busy, mc_wb_valid, stall);
      n_cmp++; if (mc_busy !== (c <= 12)) begin n_bad++; $display("FAIL db_busy c%0d: got %0b expected %0b", c, mc_busy, c <= 12); end
      n_cmp++; if (mc_wb_valid !== (c == 12)) begin n_bad++; $display("FAIL db_valid c%0d: got %0b expected %0b", c, mc_wb_valid, c == 12); end
      n_cmp++; if (stall !== (c == 3) || flush_ex !== stall) begin n_bad++; $display("FAIL db_stall c%0d: got %0b/%0b expected %0b", c, stall, flush_ex, c == 3); end
      if (c == 12) begin
        n_cmp++; if (mc_wb_rd !== 5'd4 || mc_wb_fp !== 1'b0) begin n_bad++; $display("FAIL db_tag: got rd=%0d fp=%0b expected 4/0", mc_wb_rd, mc_wb_fp); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_busy();
    clear_inputs();
    EX_mc_start = 1; EX_rd = 6; EX_reg_wr_en = 1;
    tick();
    clear_inputs();
    for (int c = 1; c <= 4; c++) begin
      EX_mc_start = (c == 2);
      rst = (c == 4);
      settle();
      $display("abort cycle %0d: busy=%0b err=%0b", c, mc_busy, mc_err);
      n_cmp++; if (mc_err !== (c >= 3)) begin n_bad++; $display("FAIL abort_err c%0d: got %0b expected %0b", c, mc_err, c >= 3); end
      n_cmp++; if (mc_busy !== (c <= 3)) begin n_bad++; $display("FAIL abort_busy c%0d: got %0b expected %0b", c, mc_busy, c <= 3); end
      tick();
    end
    clear_inputs();
    rst = 0;
    for (int c = 5; c <= 20; c++) begin
      settle();
      n_cmp++; if (mc_busy !== 1'b0 || mc_wb_valid !== 1'b0 || mc_err !== 1'b0) begin n_bad++; $display("FAIL abort_after c%0d: got busy=%0b valid=%0b err=%0b expected 0/0/0", c, mc_busy, mc_wb_valid, mc_err); end
      tick();
    end
    $display("abort: no writeback after reset, err=%0b", mc_err);
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      ID_rs1 = 5'($urandom_range(0, 7)); ID_rs2 = 5'($urandom_range(0, 7));
      ID_rs3 = 5'($urandom_range(0, 7)); ID_rd  = 5'($urandom_range(0, 7));
      ID_rs_use = 3'($urandom); ID_rs_fp = 3'($urandom);
      ID_rd_we = 1'($urandom); ID_rd_fp = 1'($urandom);
      ID_is_mc = ($urandom_range(0, 7) == 0);
      EX_rs1 = 5'($urandom_range(0, 7)); EX_rs2 = 5'($urandom_range(0, 7));
      EX_rs3 = 5'($urandom_range(0, 7)); EX_rd  = 5'($urandom_range(0, 7));
      EX_rs_fp = 3'($urandom);
      EX_reg_wr_en = 1'($urandom); EX_freg_wr_en = 1'($urandom);
      EX_is_load = 1'($urandom);
      EX_mc_start = ($urandom_range(0, 15) == 0);
      MEM_rd = 5'($urandom_range(0, 7)); MEM_reg_wr_en = 1'($urandom); MEM_freg_wr_en = 1'($urandom);
      WB_rd = 5'($urandom_range(0, 7)); WB_reg_wr_en = 1'($urandom); WB_freg_wr_en = 1'($urandom);
      settle();
      $display("rand %0d: sel=%0d/%0d/%0d stall=%0b busy=%0b valid=%0b rd=%0d fp=%0b err=%0b",
               t, EX_fwd_sel1, EX_fwd_sel2, EX_fwd_sel3, stall, mc_busy, mc_wb_valid, mc_wb_rd, mc_wb_fp, mc_err);
      n_cmp++; if (EX_fwd_sel1 !== e_sel[0]) begin n_bad++; $display("FAIL rand_sel1 t%0d: got %0d expected %0d", t, EX_fwd_sel1, e_sel[0]); end
      n_cmp++; if (EX_fwd_sel2 !== e_sel[1]) begin n_bad++; $display("FAIL rand_sel2 t%0d: got %0d expected %0d", t, EX_fwd_sel2, e_sel[1]); end
      n_cmp++; if (EX_fwd_sel3 !== e_sel[2]) begin n_bad++; $display("FAIL rand_sel3 t%0d: got %0d expected %0d", t, EX_fwd_sel3, e_sel[2]); end
      n_cmp++; if (stall !== e_stall || flush_ex !== e_stall) begin n_bad++; $display("FAIL rand_stall t%0d: got %0b/%0b expected %0b", t, stall, flush_ex, e_stall); end
      n_cmp++; if (mc_busy !== e_busy) begin n_bad++; $display("FAIL rand_busy t%0d: got %0b expected %0b", t, mc_busy, e_busy); end
      n_cmp++; if (mc_wb_valid !== e_valid) begin n_bad++; $display("FAIL rand_valid t%0d: got %0b expected %0b", t, mc_wb_valid, e_valid); end
      n_cmp++; if (mc_wb_rd !== e_rd || mc_wb_fp !== e_fp) begin n_bad++; $display("FAIL rand_tag t%0d: got %0d/%0b expected %0d/%0b", t, mc_wb_rd, mc_wb_fp, e_rd, e_fp); end
      n_cmp++; if (mc_err !== e_err) begin n_bad++; $display("FAIL rand_err t%0d: got %0b expected %0b", t, mc_err, e_err); end
      tick();
    end
  endtask

  initial begin
    m_active = 0; m_elapsed = 0; m_rd = '0; m_fp = 0; m_err = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_timing();
    test_done_blocked();
    test_reset_mid_busy();
    rst = 1;
    tick();
    rst = 0;
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
